// File: rtl/skin_mask_bbox_if.sv
// Pixel stream in, binary mask stream and per-frame skin bounding box out.
// slave: skin_mask_bbox side; master: pixel source / result consumer side.
interface skin_mask_bbox_if;
  logic [7:0]  Y;
  logic [7:0]  Cb;
  logic [7:0]  Cr;
  logic        in_hsync;
  logic        in_vsync;
  logic        in_de;
  logic [7:0]  mask;
  logic        out_hsync;
  logic        out_vsync;
  logic        out_de;
  logic [10:0] bb_x_min;
  logic [10:0] bb_x_max;
  logic [9:0]  bb_y_min;
  logic [9:0]  bb_y_max;
  logic [20:0] bb_count;
  logic        bb_valid;

  modport master (
    output Y, Cb, Cr, in_hsync, in_vsync, in_de,
    input  mask, out_hsync, out_vsync, out_de,
    input  bb_x_min, bb_x_max, bb_y_min, bb_y_max,
    input  bb_count, bb_valid
  );

  modport slave (
    input  Y, Cb, Cr, in_hsync, in_vsync, in_de,
    output mask, out_hsync, out_vsync, out_de,
    output bb_x_min, bb_x_max, bb_y_min, bb_y_max,
    output bb_count, bb_valid
  );
endinterface

// File: rtl/skin_mask_bbox.sv
// Skin classifier: YCbCr window test -> 8-bit mask (2-cycle latency, syncs
// delayed to match) plus per-frame skin pixel count and bounding box.
// Ports: clk, rst_n (sync, active-low), ce (clock enable), bus (slave):
//   Y/Cb/Cr/in_* in; mask/out_* out; bb_* result, bb_valid 1-clk pulse.
// Option: SKIN_BBOX_OVERLAY_EN draws the last published box as 8'h80.
module skin_mask_bbox #(
  parameter int IMG_W  = 1280,
  parameter int IMG_H  = 720,
  parameter int Y_MIN  = 40,
  parameter int CB_MIN = 77,
  parameter int CB_MAX = 127,
  parameter int CR_MIN = 133,
  parameter int CR_MAX = 173
) (
  input logic            clk,
  input logic            rst_n,
  input logic            ce,
  skin_mask_bbox_if.slave bus
);

  typedef enum logic {WAIT_VS, ACTIVE} state_t;

  localparam logic [7:0]  Y_LO   = 8'(Y_MIN);
  localparam logic [7:0]  CB_LO  = 8'(CB_MIN);
  localparam logic [7:0]  CB_HI  = 8'(CB_MAX);
  localparam logic [7:0]  CR_LO  = 8'(CR_MIN);
  localparam logic [7:0]  CR_HI  = 8'(CR_MAX);
  localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
  localparam logic [9:0]  Y_LAST = 10'(IMG_H - 1);
  localparam logic [20:0] C_MAX  = '1;

  state_t      state;
  logic        vs_q;
  logic        act_q;
  logic        pub;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        skin_s1;
  logic        hs_s1;
  logic        vs_s1;
  logic        de_s1;
  logic [10:0] x_s1;
  logic [9:0]  y_s1;
  logic [10:0] acc_x_min;
  logic [10:0] acc_x_max;
  logic [9:0]  acc_y_min;
  logic [9:0]  acc_y_max;
  logic [20:0] acc_cnt;

  logic        act;
  logic        skin;
  logic        vs_rise;
  logic        de_fall;
  logic [7:0]  mask_d;

  // de during vsync is not an active pixel
  assign act = bus.in_de & ~bus.in_vsync;

  assign skin = act
              & (bus.Y  >= Y_LO)
              & (bus.Cb >= CB_LO) & (bus.Cb <= CB_HI)
              & (bus.Cr >= CR_LO) & (bus.Cr <= CR_HI);

  assign vs_rise = bus.in_vsync & ~vs_q;
  assign de_fall = act_q & ~act;

`ifdef SKIN_BBOX_OVERLAY_EN
  logic in_x;
  logic in_y;
  logic on_col;
  logic on_row;
  logic border;

  assign in_x = (x_s1 >= bus.bb_x_min)
              & (x_s1 <= bus.bb_x_max);
  assign in_y = (y_s1 >= bus.bb_y_min)
              & (y_s1 <= bus.bb_y_max);
  assign on_col = (x_s1 == bus.bb_x_min)
                | (x_s1 == bus.bb_x_max);
  assign on_row = (y_s1 == bus.bb_y_min)
                | (y_s1 == bus.bb_y_max);
  assign border = de_s1 & ~vs_s1
                & (bus.bb_count != '0)
                & ((on_col & in_y) | (on_row & in_x));
  assign mask_d = border ? 8'h80 : {8{skin_s1}};
`else
  assign mask_d = {8{skin_s1}};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= WAIT_VS;
      vs_q          <= 1'b0;
      act_q         <= 1'b0;
      pub           <= 1'b0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      skin_s1       <= 1'b0;
      hs_s1         <= 1'b0;
      vs_s1         <= 1'b0;
      de_s1         <= 1'b0;
      x_s1          <= '0;
      y_s1          <= '0;
      acc_x_min     <= '1;
      acc_x_max     <= '0;
      acc_y_min     <= '1;
      acc_y_max     <= '0;
      acc_cnt       <= '0;
      bus.mask      <= '0;
      bus.out_hsync <= 1'b0;
      bus.out_vsync <= 1'b0;
      bus.out_de    <= 1'b0;
      bus.bb_x_min  <= '0;
      bus.bb_x_max  <= '0;
      bus.bb_y_min  <= '0;
      bus.bb_y_max  <= '0;
      bus.bb_count  <= '0;
      bus.bb_valid  <= 1'b0;
    end else begin
      // publish request lives one clk, independent of ce
      pub          <= 1'b0;
      bus.bb_valid <= pub;

      if (ce) begin
        vs_q  <= bus.in_vsync;
        act_q <= act;

        if (vs_rise)
          y_cnt <= '0;
        else if (de_fall && y_cnt != Y_LAST)
          y_cnt <= y_cnt + 10'd1;

        if (act) begin
          if (x_cnt != X_LAST)
            x_cnt <= x_cnt + 11'd1;
        end else if (de_fall) begin
          x_cnt <= '0;
        end

        skin_s1 <= skin;
        hs_s1   <= bus.in_hsync;
        vs_s1   <= bus.in_vsync;
        de_s1   <= bus.in_de;
        x_s1    <= x_cnt;
        y_s1    <= y_cnt;

        bus.mask      <= mask_d;
        bus.out_hsync <= hs_s1;
        bus.out_vsync <= vs_s1;
        bus.out_de    <= de_s1;

        if (state == ACTIVE && skin_s1) begin
          if (x_s1 < acc_x_min) acc_x_min <= x_s1;
          if (x_s1 > acc_x_max) acc_x_max <= x_s1;
          if (y_s1 < acc_y_min) acc_y_min <= y_s1;
          if (y_s1 > acc_y_max) acc_y_max <= y_s1;
          if (acc_cnt != C_MAX) acc_cnt <= acc_cnt + 21'd1;
        end

        if (vs_rise) begin
          if (state == WAIT_VS) begin
            state     <= ACTIVE;
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
            acc_cnt   <= '0;
          end else begin
            pub <= 1'b1;
          end
        end
      end

      // S1 holds the vsync pixel (never skin) here, so the
      // clear below cannot lose an accumulation
      if (pub) begin
        if (acc_cnt == '0) begin
          bus.bb_x_min <= '0;
          bus.bb_x_max <= '0;
          bus.bb_y_min <= '0;
          bus.bb_y_max <= '0;
        end else begin
          bus.bb_x_min <= acc_x_min;
          bus.bb_x_max <= acc_x_max;
          bus.bb_y_min <= acc_y_min;
          bus.bb_y_max <= acc_y_max;
        end
        bus.bb_count <= acc_cnt;
        acc_x_min    <= '1;
        acc_x_max    <= '0;
        acc_y_min    <= '1;
        acc_y_max    <= '0;
        acc_cnt      <= '0;
      end
    end
  end

endmodule
